// File: rtl/tof_pkg.sv
// Shared defaults and FSM encoding for the ToF phase-sweep controller and its divider datapath.
package tof_pkg;

    localparam int TOF_DIVISOR_BITS  = 8;
    localparam int TOF_SETTLE_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RESET_DIV = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_DWELL     = 3'd4
    } tof_state_e;

endpackage

// File: rtl/tof_phase_sweep_ctrl_if.sv
// Divider control bus: divisor/phase/reset toward the two-phase divider, divided clock back.
// Pure wiring, no latency; the divider never stalls the controller.
interface tof_phase_sweep_ctrl_if #(
    parameter int DIVISOR_BITS = tof_pkg::TOF_DIVISOR_BITS
);
    logic                    div_rst;
    logic [DIVISOR_BITS-1:0] div_divisor;
    logic [DIVISOR_BITS-1:0] div_phase;
    logic                    clk_ref;

    modport master (output div_rst, output div_divisor, output div_phase, input clk_ref);
    modport slave  (input div_rst, input div_divisor, input div_phase, output clk_ref);
endinterface

// File: rtl/phase_accum_mod.sv
// Modular phase accumulator: load (phase=0, inc=step mod divisor), clear, advance by inc mod divisor.
// Result registered one cycle after the command; no backpressure, commands act immediately.
module phase_accum_mod
    import tof_pkg::*;
#(
    parameter int W = TOF_DIVISOR_BITS
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] divisor,
    input  logic [W-1:0] step,
    output logic [W-1:0] phase
);
    logic [W-1:0] inc;
    logic [W-1:0] div_q;
    logic [W-1:0] step_mod;
    logic [W:0]   sum;

    // Restoring remainder: one conditional subtract per step bit, settles in a single cycle.
    function automatic logic [W-1:0] mod_reduce(input logic [W-1:0] a, input logic [W-1:0] d);
        logic [W:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            r = {r[W-1:0], a[i]};
            if (r >= {1'b0, d}) begin
                r = r - {1'b0, d};
            end
        end
        return r[W-1:0];
    endfunction

    assign step_mod = mod_reduce(step, divisor);
    assign sum      = {1'b0, phase} + {1'b0, inc};

    always_ff @(posedge clk_in) begin
        if (rst) begin
            phase <= '0;
            inc   <= '0;
            div_q <= '0;
        end else if (load) begin
            phase <= '0;
            inc   <= step_mod;
            div_q <= divisor;
        end else if (clear) begin
            phase <= '0;
        end else if (advance) begin
            phase <= (sum >= {1'b0, div_q}) ? W'(sum - {1'b0, div_q}) : sum[W-1:0];
        end
    end

endmodule

// File: rtl/tof_phase_sweep_ctrl.sv
// Steps the clock divider through a phase sweep, holding a dwell window of N divided periods per step.
// Outputs registered (1 cycle after decision); start ignored while busy, abort wins over everything.
module tof_phase_sweep_ctrl
    import tof_pkg::*;
#(
    parameter int DIVISOR_BITS  = TOF_DIVISOR_BITS,
    parameter int DWELL_BITS    = 16,
    parameter int STEP_BITS     = 4,
    parameter int SETTLE_CYCLES = TOF_SETTLE_CYCLES
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DIVISOR_BITS-1:0] cfg_divisor,
    input  logic [DIVISOR_BITS-1:0] cfg_phase_step,
    input  logic [STEP_BITS-1:0]    cfg_num_steps,
    input  logic [DWELL_BITS-1:0]   cfg_dwell,
    input  logic                    cfg_loop,
    tof_phase_sweep_ctrl_if.master  div_if,
    output logic                    busy,
    output logic                    step_valid,
    output logic [STEP_BITS-1:0]    step_idx,
    output logic                    step_done,
    output logic                    sweep_done,
    output logic                    cfg_err
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 2);

    tof_state_e              state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [DWELL_BITS-1:0]   dwell_cnt, dwell_nxt;
    logic [STEP_BITS-1:0]    idx_nxt;

    logic [DIVISOR_BITS-1:0] sh_divisor;
    logic [DIVISOR_BITS-1:0] sh_phase_step;
    logic [STEP_BITS-1:0]    sh_num_steps;
    logic [DWELL_BITS-1:0]   sh_dwell;
    logic                    sh_loop;

    logic [DIVISOR_BITS-1:0] divisor_q;
    logic [DIVISOR_BITS-1:0] phase;
    logic                    shadow_ld, acc_load, acc_clear, acc_adv;
    logic                    step_done_nxt, sweep_done_nxt, cfg_err_nxt;
    logic                    div_rst, clk_ref_d, ref_rise;
    logic                    cfg_bad, last_step, dwell_end;

    // Status outputs decode the registered state, so they change on the same edge as the state.
    assign busy       = (state != ST_IDLE);
    assign step_valid = (state == ST_DWELL);
    assign div_rst    = !((state == ST_SETTLE) || (state == ST_DWELL));

    assign ref_rise  = div_if.clk_ref & ~clk_ref_d;
    assign cfg_bad   = (cfg_divisor < DIVISOR_BITS'(2)) || (cfg_num_steps == '0) || (cfg_dwell == '0);
    assign last_step = (step_idx == sh_num_steps - STEP_BITS'(1));
    assign dwell_end = (dwell_cnt == sh_dwell - DWELL_BITS'(1));

    assign div_if.div_rst     = div_rst;
    assign div_if.div_divisor = divisor_q;
    assign div_if.div_phase   = phase;

    phase_accum_mod #(
        .W (DIVISOR_BITS)
    ) u_phase_accum (
        .clk_in  (clk_in),
        .rst     (rst),
        .load    (acc_load),
        .clear   (acc_clear),
        .advance (acc_adv),
        .divisor (sh_divisor),
        .step    (sh_phase_step),
        .phase   (phase)
    );

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        dwell_nxt      = dwell_cnt;
        idx_nxt        = step_idx;
        shadow_ld      = 1'b0;
        acc_load       = 1'b0;
        acc_clear      = 1'b0;
        acc_adv        = 1'b0;
        step_done_nxt  = 1'b0;
        sweep_done_nxt = 1'b0;
        cfg_err_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        shadow_ld = 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                acc_load  = 1'b1;
                idx_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = ST_RESET_DIV;
            end
            ST_RESET_DIV: begin
                if (cnt == CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_SETTLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                // Edges seen while the divider is still coming out of reset are ignored.
                if (cnt < CNT_W'(SETTLE_CYCLES)) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else if (ref_rise) begin
                    dwell_nxt = '0;
                    state_nxt = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (ref_rise) begin
                    if (dwell_end) begin
                        step_done_nxt = 1'b1;
                        cnt_nxt       = '0;
                        state_nxt     = ST_RESET_DIV;
                        if (last_step) begin
                            sweep_done_nxt = 1'b1;
                            if (sh_loop) begin
                                idx_nxt   = '0;
                                acc_clear = 1'b1;
                            end else begin
                                state_nxt = ST_IDLE;
                            end
                        end else begin
                            idx_nxt = step_idx + STEP_BITS'(1);
                            acc_adv = 1'b1;
                        end
                    end else begin
                        dwell_nxt = dwell_cnt + DWELL_BITS'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (abort) begin
            state_nxt      = ST_IDLE;
            shadow_ld      = 1'b0;
            acc_load       = 1'b0;
            acc_clear      = 1'b0;
            acc_adv        = 1'b0;
            step_done_nxt  = 1'b0;
            sweep_done_nxt = 1'b0;
            cfg_err_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            dwell_cnt     <= '0;
            step_idx      <= '0;
            step_done     <= 1'b0;
            sweep_done    <= 1'b0;
            cfg_err       <= 1'b0;
            clk_ref_d     <= 1'b0;
            divisor_q     <= '0;
            sh_divisor    <= '0;
            sh_phase_step <= '0;
            sh_num_steps  <= '0;
            sh_dwell      <= '0;
            sh_loop       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dwell_cnt  <= dwell_nxt;
            step_idx   <= idx_nxt;
            step_done  <= step_done_nxt;
            sweep_done <= sweep_done_nxt;
            cfg_err    <= cfg_err_nxt;
            clk_ref_d  <= div_rst ? 1'b0 : div_if.clk_ref;
            if (shadow_ld) begin
                sh_divisor    <= cfg_divisor;
                sh_phase_step <= cfg_phase_step;
                sh_num_steps  <= cfg_num_steps;
                sh_dwell      <= cfg_dwell;
                sh_loop       <= cfg_loop;
            end
            if (acc_load) begin
                divisor_q <= sh_divisor;
            end
        end
    end

endmodule
